// File: rtl/fpu_class_gen_pkg.sv
// Shared types and helpers for the FP class stimulus generator.
// Value construction and LFSR stepping live here so all users agree.
package fpu_class_gen_pkg;

  typedef logic [9:0] fclass_mask_t;

  localparam int CLS_NEG_INF  = 0;
  localparam int CLS_NEG_NORM = 1;
  localparam int CLS_NEG_SUB  = 2;
  localparam int CLS_NEG_ZERO = 3;
  localparam int CLS_POS_ZERO = 4;
  localparam int CLS_POS_SUB  = 5;
  localparam int CLS_POS_NORM = 6;
  localparam int CLS_POS_INF  = 7;
  localparam int CLS_SNAN     = 8;
  localparam int CLS_QNAN     = 9;

  localparam logic [7:0]  EXP_ONES     = 8'hFF;
  localparam logic [7:0]  EXP_MAX_NORM = 8'hFE;
  localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;

  typedef enum logic {IDLE, GEN} gen_state_t;

  function automatic logic is_onehot(fclass_mask_t m);
    return (m != '0) && ((m & (m - 10'd1)) == '0);
  endfunction

  function automatic logic [31:0] lfsr_step(logic [31:0] r);
    return {1'b0, r[31:1]} ^ (r[0] ? LFSR_TAPS : 32'h0);
  endfunction

  function automatic logic [31:0] build_value(
    fclass_mask_t cls,
    logic [31:0]  r
  );
    logic        s;
    logic [7:0]  e;
    logic [22:0] f;
    logic [21:0] p;
    logic [31:0] v;
    s = |cls[CLS_NEG_ZERO:CLS_NEG_INF];
    e = r[30:23];
    f = r[22:0];
    p = r[21:0];
    v = '0;
    unique case (1'b1)
      cls[CLS_NEG_INF], cls[CLS_POS_INF]:
        v = {s, EXP_ONES, 23'h0};
      cls[CLS_NEG_ZERO], cls[CLS_POS_ZERO]:
        v = {s, 31'h0};
      cls[CLS_NEG_SUB], cls[CLS_POS_SUB]:
        v = {s, 8'h00, (f == '0) ? 23'h1 : f};
      cls[CLS_NEG_NORM], cls[CLS_POS_NORM]: begin
        if (e == 8'h00)
          e = 8'h01;
        else if (e == EXP_ONES)
          e = EXP_MAX_NORM;
        v = {s, e, f};
      end
      cls[CLS_SNAN]:
        v = {r[31], EXP_ONES, 1'b0, (p == '0) ? 22'h1 : p};
      cls[CLS_QNAN]:
        v = {r[31], EXP_ONES, 1'b1, p};
      default:
        v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/fpu_class_gen_if.sv
// Request and output beat stream of the class generator.
// master drives requests and sink ready; slave is the generator.
interface fpu_class_gen_if;
  import fpu_class_gen_pkg::*;

  logic         req_valid;
  logic         req_ready;
  fclass_mask_t req_class;
  logic [7:0]   req_count;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  fclass_mask_t out_class;
  logic         out_last;
  logic         err;

  modport master (
    output req_valid, req_class, req_count, out_ready,
    input  req_ready, out_valid, out_data, out_class,
    input  out_last, err
  );

  modport slave (
    input  req_valid, req_class, req_count, out_ready,
    output req_ready, out_valid, out_data, out_class,
    output out_last, err
  );

endinterface

// File: rtl/fpu_class_gen_lfsr.sv
// 32-bit Galois LFSR with seed load and step enable.
// A zero seed would lock up, so it is replaced by 1.
module fpu_lfsr32
  import fpu_class_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        adv,
  output logic [31:0] state
);

  logic [31:0] seed_nz;
  logic [31:0] state_d;
  logic [31:0] state_q;

  assign seed_nz = (seed == '0) ? 32'h1 : seed;

  always_comb begin
    state_d = state_q;
    if (load)
      state_d = seed_nz;
    else if (adv)
      state_d = lfsr_step(state_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      state_q <= seed_nz;
    else
      state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/fpu_class_gen.sv
// Emits a burst of random single-precision values of one
// requested fclass over a valid/ready stream.
module fpu_class_gen
  import fpu_class_gen_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_2468
) (
  input logic           clk,
  input logic           rst_n,
  fpu_class_gen_if.slave bus
);

  gen_state_t   state_d, state_q;
  logic         req_ready_d, req_ready_q;
  logic         out_valid_d, out_valid_q;
  logic [31:0]  out_data_d, out_data_q;
  fclass_mask_t out_class_d, out_class_q;
  logic         out_last_d, out_last_q;
  logic         err_d, err_q;
  logic [8:0]   rem_d, rem_q;
  logic         lfsr_load;
  logic         lfsr_adv;
  logic [31:0]  lfsr_state;
  logic         accept;
  logic         hs;

  fpu_lfsr32 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .seed  (SEED),
    .adv   (lfsr_adv),
    .state (lfsr_state)
  );

  assign accept = bus.req_valid && req_ready_q;
  assign hs     = out_valid_q && bus.out_ready;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_class_d = out_class_q;
    out_last_d  = out_last_q;
    err_d       = 1'b0;
    rem_d       = rem_q;
    lfsr_load   = 1'b0;
    lfsr_adv    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_onehot(bus.req_class)) begin
            state_d     = GEN;
            lfsr_load   = 1'b1;
            out_class_d = bus.req_class;
            rem_d = (bus.req_count == '0) ? 9'd256
                  : {1'b0, bus.req_count};
          end else begin
            err_d = 1'b1;
          end
        end
      end
      GEN: begin
        // First beat comes from the freshly loaded seed
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = build_value(out_class_q, lfsr_state);
          out_last_d  = (rem_q == 9'd1);
        end else if (hs) begin
          lfsr_adv = 1'b1;
          rem_d    = rem_q - 9'd1;
          if (out_last_q) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end else begin
            out_data_d = build_value(out_class_q,
                                     lfsr_step(lfsr_state));
            out_last_d = (rem_d == 9'd1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_class_q <= '0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
      rem_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_class_q <= out_class_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
      rem_q       <= rem_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_class = out_class_q;
  assign bus.out_last  = out_last_q;
  assign bus.err       = err_q;

endmodule
